// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between two requesters and the shared
// logic unit arbiter.
interface logic_unit_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req_valid_0;
    logic              req_ready_0;
    logic [1:0]        req_op_0;
    logic [DATA_W-1:0] req_a_0;
    logic [DATA_W-1:0] req_b_0;

    logic              req_valid_1;
    logic              req_ready_1;
    logic [1:0]        req_op_1;
    logic [DATA_W-1:0] req_a_1;
    logic [DATA_W-1:0] req_b_1;

    logic              resp_valid_0;
    logic              resp_ready_0;
    logic              resp_valid_1;
    logic              resp_ready_1;
    logic [DATA_W-1:0] resp_data;
    logic              resp_zero;

    modport master (
        output req_valid_0, req_op_0, req_a_0, req_b_0,
        output req_valid_1, req_op_1, req_a_1, req_b_1,
        input  req_ready_0, req_ready_1,
        output resp_ready_0, resp_ready_1,
        input  resp_valid_0, resp_valid_1,
        input  resp_data, resp_zero
    );

    modport slave (
        input  req_valid_0, req_op_0, req_a_0, req_b_0,
        input  req_valid_1, req_op_1, req_a_1, req_b_1,
        output req_ready_0, req_ready_1,
        input  resp_ready_0, resp_ready_1,
        output resp_valid_0, resp_valid_1,
        output resp_data, resp_zero
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between two
// requesters; result is held until the owning requester takes it.
module logic_unit_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_unit_arbiter_if.slave  bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     ops_done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              owner;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic              zero_q;
    logic [DATA_W-1:0] f;
    logic              gnt0;
    logic              gnt1;
    logic              rdy0;
    logic              rdy1;
    logic              rv0;
    logic              rv1;
    logic              acc;
    logic              rsp_hs;

    // Tie goes to the requester that did not win last time.
    always_comb begin
        gnt1 = bus.req_valid_1 & (~bus.req_valid_0 | ~last_grant);
        gnt0 = bus.req_valid_0 & ~gnt1;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        rv0       = 1'b0;
        rv1       = 1'b0;
        acc       = 1'b0;
        rsp_hs    = 1'b0;
        unique case (state)
            IDLE: begin
                rdy0 = gnt0;
                rdy1 = gnt1;
                acc  = gnt0 | gnt1;
                if (acc) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rv0    = ~owner;
                rv1    = owner;
                rsp_hs = owner ? bus.resp_ready_1
                               : bus.resp_ready_0;
                if (rsp_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The logic unit itself, fed from the operation register.
    always_comb begin
        f = '0;
        unique case (op_q)
            2'b00: f = a_q & b_q;
            2'b01: f = a_q | b_q;
            2'b10: f = a_q ^ b_q;
            2'b11: f = ~(a_q | b_q);
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Latch the granted operation and remember the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (acc) begin
            op_q       <= gnt1 ? bus.req_op_1 : bus.req_op_0;
            a_q        <= gnt1 ? bus.req_a_1 : bus.req_a_0;
            b_q        <= gnt1 ? bus.req_b_1 : bus.req_b_0;
            owner      <= gnt1;
            last_grant <= gnt1;
        end
    end

    // Registered execute step; result persists after the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            zero_q <= 1'b1;
        end else if (state == EXEC) begin
            res_q  <= f;
            zero_q <= (f == '0);
        end
    end

    // Count completed response handshakes, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ops_done <= '0;
        else if (rsp_hs) ops_done <= ops_done + 1'b1;
    end

    assign bus.req_ready_0  = rdy0;
    assign bus.req_ready_1  = rdy1;
    assign bus.resp_valid_0 = rv0;
    assign bus.resp_valid_1 = rv1;
    assign bus.resp_data    = res_q;
    assign bus.resp_zero    = zero_q;
    assign busy             = (state != IDLE);
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: directed scenarios plus
// randomized two-requester traffic against a behavioural model.
module tb_logic_unit_arbiter;
    localparam int DW = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic [CW-1:0] ops_done;

    always #5 clk = ~clk;

    logic_unit_arbiter_if #(.DATA_W(DW)) bus ();

    logic_unit_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .ops_done (ops_done)
    );

    logic          v  [2];
    logic [1:0]    op [2];
    logic [DW-1:0] a  [2];
    logic [DW-1:0] b  [2];
    logic          rr [2];

    assign bus.req_valid_0  = v[0];
    assign bus.req_op_0     = op[0];
    assign bus.req_a_0      = a[0];
    assign bus.req_b_0      = b[0];
    assign bus.req_valid_1  = v[1];
    assign bus.req_op_1     = op[1];
    assign bus.req_a_1      = a[1];
    assign bus.req_b_1      = b[1];
    assign bus.resp_ready_0 = rr[0];
    assign bus.resp_ready_1 = rr[1];

    int checks = 0;
    int errors = 0;

    logic [DW:0] sbq [$];
    int          gseq [$];
    bit          m_lg = 1'b1;
    bit          m_busy = 1'b0;
    bit          first_resp = 1'b0;
    bit          od_pend = 1'b0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          done_cnt = 0;
    bit          hs_seen [2];
    bit          done_f [2];

    logic [1:0]    fop [2];
    logic [DW-1:0] fa  [2];
    logic [DW-1:0] fb  [2];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] lu(input logic [1:0] o,
                                         input logic [DW-1:0] x,
                                         input logic [DW-1:0] y);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    // Monitor: arbitration rule, latency, scoreboard and counter.
    always @(negedge clk) begin
        logic        r0, r1, eg0, eg1, own, eo;
        logic [DW:0] e;
        if (rst_n) begin
            cyc++;
            r0 = bus.req_ready_0;
            r1 = bus.req_ready_1;
            if (od_pend) begin
                chk("ops_done", 32'(ops_done),
                    32'(done_cnt % (1 << CW)));
                od_pend = 1'b0;
            end
            chk("busy", busy, m_busy);
            if (!m_busy) begin
                eg0 = v[0] && (!v[1] || m_lg);
                eg1 = v[1] && !eg0;
                chk("grant", {r1, r0}, {eg1, eg0});
                if ((r0 && v[0]) || (r1 && v[1])) begin
                    own = r1 && v[1];
                    sbq.push_back({own, lu(op[own], a[own], b[own])});
                    gseq.push_back(int'(own));
                    m_lg = own;
                    m_busy = 1'b1;
                    acc_cyc = cyc;
                    first_resp = 1'b1;
                    hs_seen[own] = 1'b1;
                end
            end else begin
                chk("ready_while_busy", {r1, r0}, 2'b00);
            end
            if (bus.resp_valid_0 || bus.resp_valid_1) begin
                if (sbq.size() == 0) begin
                    chk("resp_unexpected",
                        {bus.resp_valid_1, bus.resp_valid_0}, 0);
                end else begin
                    e  = sbq[0];
                    eo = e[DW];
                    chk("resp_owner",
                        {bus.resp_valid_1, bus.resp_valid_0},
                        eo ? 2'b10 : 2'b01);
                    chk("resp_data", bus.resp_data, e[DW-1:0]);
                    chk("resp_zero", bus.resp_zero, e[DW-1:0] == '0);
                    if (first_resp) begin
                        chk("latency", cyc - acc_cyc, 2);
                        first_resp = 1'b0;
                    end
                    if (eo ? (bus.resp_valid_1 && rr[1])
                           : (bus.resp_valid_0 && rr[0])) begin
                        void'(sbq.pop_front());
                        done_cnt++;
                        od_pend = 1'b1;
                        m_busy = 1'b0;
                    end
                end
            end else if (first_resp && (cyc - acc_cyc) > 2) begin
                chk("resp_timeout", cyc - acc_cyc, 2);
                first_resp = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (hs_seen[i]) begin
                hs_seen[i] = 1'b0;
                v[i] = 1'b0;
                done_f[i] = 1'b1;
            end
        end
    endtask

    task automatic model_clear();
        sbq.delete();
        gseq.delete();
        m_lg = 1'b1;
        m_busy = 1'b0;
        first_resp = 1'b0;
        od_pend = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            hs_seen[i] = 1'b0;
            done_f[i] = 1'b0;
            v[i] = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic send(input int i, input logic [1:0] o,
                        input logic [DW-1:0] x,
                        input logic [DW-1:0] y);
        int n;
        op[i] = o;
        a[i] = x;
        b[i] = y;
        v[i] = 1'b1;
        done_f[i] = 1'b0;
        n = 0;
        while (!done_f[i] && n < 50) begin
            tick();
            n++;
        end
        chk("accept", done_f[i], 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_busy || sbq.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        chk("drain", m_busy, 1'b0);
    endtask

    task automatic wait_rv0();
        int n;
        n = 0;
        while (!bus.resp_valid_0 && n < 10) begin
            tick();
            n++;
        end
        chk("resp_valid_0_seen", bus.resp_valid_0, 1'b1);
    endtask

    function automatic logic [DW-1:0] pick();
        case ($urandom_range(3))
            0:       return '0;
            1:       return '1;
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic run(input int ncyc, input int pv, input int pr,
                       input bit fixed);
        for (int k = 0; k < ncyc; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (!v[i]) begin
                    if ($urandom_range(99) < pv) begin
                        op[i] = fixed ? fop[i] : 2'($urandom_range(3));
                        a[i]  = fixed ? fa[i] : pick();
                        b[i]  = fixed ? fb[i] : pick();
                        v[i]  = 1'b1;
                    end
                end else if (!fixed && $urandom_range(99) < 5) begin
                    v[i] = 1'b0;
                end
                rr[i] = ($urandom_range(99) < pr);
            end
        end
        v[0] = 1'b0;
        v[1] = 1'b0;
        rr[0] = 1'b1;
        rr[1] = 1'b1;
    endtask

    task automatic check_reset_state();
        chk("rst_ready_0", bus.req_ready_0, 1'b0);
        chk("rst_ready_1", bus.req_ready_1, 1'b0);
        chk("rst_resp_valid_0", bus.resp_valid_0, 1'b0);
        chk("rst_resp_valid_1", bus.resp_valid_1, 1'b0);
        chk("rst_resp_data", bus.resp_data, 32'h0);
        chk("rst_resp_zero", bus.resp_zero, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ops_done", 32'(ops_done), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            op[i] = '0;
            a[i]  = '0;
            b[i]  = '0;
            rr[i] = 1'b1;
        end
        apply_reset();
        check_reset_state();

        // Single AND on requester 0.
        send(0, 2'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
        wait_idle();
        chk("first_ops_done", 32'(ops_done), 32'h1);
        chk("first_result", bus.resp_data, 32'hF000_F000);

        // Both valid every cycle: grants alternate.
        apply_reset();
        fop[0] = 2'd1; fa[0] = 32'h0000_00FF; fb[0] = 32'h0000_FF00;
        fop[1] = 2'd2; fa[1] = 32'hFFFF_FFFF; fb[1] = 32'hFFFF_FFFF;
        run(24, 100, 100, 1'b1);
        wait_idle();
        chk("alt_len", gseq.size() >= 4, 1'b1);
        if (gseq.size() >= 4) begin
            for (int j = 0; j < 4; j++)
                chk("alt_grant", gseq[j], j % 2);
        end

        // Owner stalls its response while requester 1 waits.
        rr[0] = 1'b0;
        send(0, 2'd1, 32'h1234_0000, 32'h0000_5678);
        op[1] = 2'd2;
        a[1] = 32'hDEAD_BEEF;
        b[1] = 32'h0F0F_0F0F;
        v[1] = 1'b1;
        done_f[1] = 1'b0;
        wait_rv0();
        repeat (5) tick();
        rr[0] = 1'b1;
        @(negedge clk);
        chk("r1_in_hs_cycle", bus.req_ready_1, 1'b0);
        @(negedge clk);
        chk("r1_after_hs", bus.req_ready_1, 1'b1);
        for (int n = 0; n < 10 && !done_f[1]; n++) tick();
        chk("r1_accepted", done_f[1], 1'b1);
        wait_idle();

        // NOR corners; result persists in IDLE.
        send(0, 2'd3, 32'h0, 32'h0);
        wait_idle();
        chk("nor00", bus.resp_data, 32'hFFFF_FFFF);
        send(1, 2'd3, 32'hFFFF_FFFF, 32'h0);
        wait_idle();
        chk("nor_f0_data", bus.resp_data, 32'h0);
        chk("nor_f0_zero", bus.resp_zero, 1'b1);

        // Reset while a response is pending.
        rr[0] = 1'b0;
        send(0, 2'd1, 32'h0000_00A5, 32'h0000_5A00);
        wait_rv0();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", bus.resp_valid_0, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ops_done", 32'(ops_done), 32'h0);
        rr[0] = 1'b1;
        apply_reset();
        check_reset_state();
        op[0] = 2'd0; a[0] = 32'hFFFF_0000; b[0] = 32'h0FF0_0FF0;
        op[1] = 2'd1; a[1] = 32'h1;         b[1] = 32'h2;
        v[0] = 1'b1; v[1] = 1'b1;
        done_f[0] = 1'b0; done_f[1] = 1'b0;
        @(negedge clk);
        chk("tie_ready_0", bus.req_ready_0, 1'b1);
        chk("tie_ready_1", bus.req_ready_1, 1'b0);
        for (int n = 0; n < 20 && !(done_f[0] && done_f[1]); n++)
            tick();
        chk("tie_both_done", done_f[0] && done_f[1], 1'b1);
        wait_idle();

        // Counter wrap with a 4-bit counter.
        apply_reset();
        for (int k = 0; k < (1 << CW) + 3; k++)
            send(0, 2'($urandom_range(3)), pick(), pick());
        wait_idle();
        tick();
        chk("wrap_ops_done", 32'(ops_done), 32'h3);

        // Randomized mixed traffic.
        run(600, 60, 70, 1'b0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
